// File: rtl/alu_seq_param_if.sv
// ---------------------------------------------------------------------------
// alu_seq_param_if
//   Start/result bus for the sequential ALU.
//   Requester side (master) drives the operands, opcode and start request.
//   ALU side (slave) returns busy, the one-cycle done pulse, the divide-by-zero
//   flag and the registered 2*WIDTH result.
//
//   portA   WIDTH     operand A (dividend / shift source / compare lhs)
//   portB   WIDTH     operand B (divisor / shift amount / compare rhs)
//   opcode  2         00 LSHIFT, 01 RSHIFT, 10 ZERO, 11 DIV
//   start   1         operation request, only looked at while idle
//   busy    1         ALU is running an operation
//   done    1         result valid pulse
//   err     1         divide-by-zero flag of the last operation
//   out     2*WIDTH   result
// ---------------------------------------------------------------------------
interface alu_seq_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   portA;
    logic [WIDTH-1:0]   portB;
    logic [1:0]         opcode;
    logic               start;
    logic               busy;
    logic               done;
    logic               err;
    logic [2*WIDTH-1:0] out;

    modport master (
        output portA, portB, opcode, start,
        input  busy, done, err, out
    );

    modport slave (
        input  portA, portB, opcode, start,
        output busy, done, err, out
    );
endinterface

// File: rtl/alu_seq_param.sv
// ---------------------------------------------------------------------------
// alu_seq_param
//   Multi-cycle ALU: left shift, logical right shift, equality test and
//   unsigned restoring divide, all sharing one IDLE/RUN/DONE state machine and
//   one 2*WIDTH working register. Operands are captured when start is seen in
//   IDLE; the result and error flag are registered and held until the next
//   operation completes.
//
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-high, highest priority
//   bus   slave modport of alu_seq_param_if (operands, opcode, start,
//         busy, done, err, out)
// ---------------------------------------------------------------------------
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_seq_param_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_LSHIFT = 2'b00;
    localparam logic [1:0] OP_RSHIFT = 2'b01;
    localparam logic [1:0] OP_ZERO   = 2'b10;
    localparam logic [1:0] OP_DIV    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               r_state;
    logic [1:0]           r_opcode;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_work;
    logic [2*WIDTH-1:0]   r_out;
    logic                 r_err;

    state_t               w_stateNext;
    logic [1:0]           w_opcodeNext;
    logic [WIDTH-1:0]     w_aNext;
    logic [WIDTH-1:0]     w_bNext;
    logic [CNT_W-1:0]     w_cntNext;
    logic [2*WIDTH-1:0]   w_workNext;
    logic [2*WIDTH-1:0]   w_outNext;
    logic                 w_errNext;

    logic [WIDTH:0]       w_trial;
    logic [WIDTH-1:0]     w_remSub;
    logic [2*WIDTH-1:0]   w_divStep;

    // One restoring-divide step. The working register holds the partial
    // remainder in its upper half and the dividend in its lower half; each
    // step pulls the next dividend bit into the remainder and shifts the new
    // quotient bit in from the bottom, so after WIDTH steps the register is
    // exactly {remainder, quotient}. The subtraction can be done WIDTH bits
    // wide because whenever it is taken the true difference is below the
    // divisor and therefore fits.
    assign w_trial   = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
    assign w_remSub  = w_trial[WIDTH-1:0] - r_b;
    assign w_divStep = (w_trial >= {1'b0, r_b})
                     ? {w_remSub, r_work[WIDTH-2:0], 1'b1}
                     : {w_trial[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};

    // Next-state and datapath decode. Everything holds by default. In IDLE a
    // start captures the operands and preloads the iteration count (shift
    // amounts saturate at WIDTH, a zero divisor skips iterating entirely).
    // In RUN each cycle either performs one iteration or, once the count is
    // exhausted, publishes the result and error flag together.
    always_comb begin
        w_stateNext  = r_state;
        w_opcodeNext = r_opcode;
        w_aNext      = r_a;
        w_bNext      = r_b;
        w_cntNext    = r_cnt;
        w_workNext   = r_work;
        w_outNext    = r_out;
        w_errNext    = r_err;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_stateNext  = RUN;
                    w_opcodeNext = bus.opcode;
                    w_aNext      = bus.portA;
                    w_bNext      = bus.portB;
                    w_workNext   = {{WIDTH{1'b0}}, bus.portA};
                    case (bus.opcode)
                        OP_LSHIFT, OP_RSHIFT: begin
                            if (bus.portB >= WIDTH'(WIDTH))
                                w_cntNext = CNT_W'(WIDTH);
                            else
                                w_cntNext = CNT_W'(bus.portB);
                        end
                        OP_DIV: begin
                            if (bus.portB == '0)
                                w_cntNext = '0;
                            else
                                w_cntNext = CNT_W'(WIDTH);
                        end
                        default: w_cntNext = '0;
                    endcase
                end
            end

            RUN: begin
                if (r_cnt == '0) begin
                    w_stateNext = DONE;
                    w_errNext   = 1'b0;
                    case (r_opcode)
                        OP_ZERO: w_outNext = {{(2*WIDTH-1){1'b0}}, (r_a == r_b)};
                        OP_DIV: begin
                            if (r_b == '0) begin
                                w_outNext = {r_a, {WIDTH{1'b1}}};
                                w_errNext = 1'b1;
                            end else begin
                                w_outNext = r_work;
                            end
                        end
                        default: w_outNext = r_work;
                    endcase
                end else begin
                    w_cntNext = r_cnt - CNT_W'(1);
                    case (r_opcode)
                        OP_LSHIFT: w_workNext = r_work << 1;
                        OP_RSHIFT: w_workNext = r_work >> 1;
                        OP_DIV:    w_workNext = w_divStep;
                        default:   w_workNext = r_work;
                    endcase
                end
            end

            DONE: w_stateNext = IDLE;

            default: w_stateNext = IDLE;
        endcase
    end

    // State and datapath registers. Reset clears the visible result and
    // flag and drops any operation in flight without publishing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_out    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_opcode <= w_opcodeNext;
            r_a      <= w_aNext;
            r_b      <= w_bNext;
            r_cnt    <= w_cntNext;
            r_work   <= w_workNext;
            r_out    <= w_outNext;
            r_err    <= w_errNext;
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
    assign bus.err  = r_err;
    assign bus.out  = r_out;
endmodule
